serial_adder: RTL and testbench

//   Multi-cycle N-bit adder built from a chain of BITS_PER_CYCLE full-adder cells.
//   - Captures two operands and a carry-in, then adds BITS_PER_CYCLE bits per clock, LSB first.
//   - Registers the carry between steps.
//   - Presents the sum, carry-out and signed overflow behind a valid/ready handshake.
//   - Serves as the area-lean successor to the single-bit full adder for datapaths where

---
 rtl/serial_adder.sv | 159 +++++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder that processes BITS_PER_CYCLE bits per
// clock through a chain of full-adder cells, LSB first, with a registered inter-step
// carry. The result is presented behind a valid/ready handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' input (a - b).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operands a/b/cin (and sub) valid
//   in_ready   block can accept operands (IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   sub        subtract request (only with SERIAL_ADDER_SUB_EN)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
module serial_adder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned BPC    = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
  localparam int unsigned STEPS  = WIDTH / BPC;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Elaboration-time parameter sanity check
  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
      (WIDTH % BPC) != 0) begin : g_param_err
    $error("serial_adder: BITS_PER_CYCLE must be in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic               in_ready_d;
  logic               out_valid_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               carry;
  logic [STEP_W-1:0]  step;
  logic [BPC-1:0]     chunk_sum;
  logic               chunk_cout;
  logic               carry_into_top;
  logic               accept;
  logic               last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (step == STEP_W'(STEPS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state, then registered
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (next_state)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Ripple chain of BPC full-adder cells; also exposes the carry into the top cell
  // so that the final step can derive signed overflow.
  always_comb begin
    logic cy;
    chunk_sum      = '0;
    carry_into_top = 1'b0;
    cy             = carry;
    for (int i = 0; i < int'(BPC); i++) begin
      carry_into_top = cy;
      chunk_sum[i]   = a_sh[i] ^ b_sh[i] ^ cy;
      cy             = (a_sh[i] & b_sh[i]) | (cy & (a_sh[i] ^ b_sh[i]));
    end
    chunk_cout = cy;
  end

  // Operand shift registers, carry, step counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      step  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
      // Subtraction as a + ~b + 1
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
`else
      b_sh  <= b;
      carry <= cin;
`endif
      step  <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> BPC;
      b_sh  <= b_sh >> BPC;
      carry <= chunk_cout;
      step  <= step + STEP_W'(1);
      // New chunk enters at the MSB end; after STEPS shifts it lands LSB-aligned
      sum   <= (sum >> BPC) | (WIDTH'(chunk_sum) << (WIDTH - BPC));
      if (last_step) begin
        cout <= chunk_cout;
        ovf  <= chunk_cout ^ carry_into_top;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven checks of serial_adder (WIDTH=8, BPC=1)
// plus a WIDTH=16 sweep over BITS_PER_CYCLE in {1,2,4,16}.
module tb_serial_adder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Sweep instances, WIDTH=16
  logic        sw_iv [4];
  logic        sw_ir [4];
  logic        sw_cin[4];
  logic        sw_ov [4];
  logic        sw_or [4];
  logic        sw_co [4];
  logic        sw_ovf[4];
  logic [15:0] sw_a  [4];
  logic [15:0] sw_b  [4];
  logic [15:0] sw_sum[4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int unsigned BPC = (k == 3) ? 16 : (1 << k);
    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(BPC)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_iv[k]), .in_ready(sw_ir[k]),
      .a(sw_a[k]), .b(sw_b[k]), .cin(sw_cin[k]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(sw_ov[k]), .out_ready(sw_or[k]),
      .sum(sw_sum[k]), .cout(sw_co[k]), .ovf(sw_ovf[k])
    );
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then count edges until out_valid (bounded)
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output int lat);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [7:0]  held;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    int          bpc;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      sw_iv[k] = 1'b0; sw_or[k] = 1'b0; sw_cin[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
    end

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check("vec latency", 32'(lat), 32'd9);
      check("vec sum", 32'(sum), 32'(vecs[i].s));
      check("vec cout", 32'(cout), 32'(vecs[i].c));
      check("vec ovf", 32'(ovf), 32'(vecs[i].o));
      release_result();
    end

    // Reset during RUN at step 3
    a = 8'h3C; b = 8'h05; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst sum", 32'(sum), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrun rst no result", 32'(seen), 32'd0);

    // Backpressure in DONE, ignored in_valid, simultaneous out_ready/in_valid
    run_op(8'h12, 8'h34, 1'b0, lat);
    check("bp latency", 32'(lat), 32'd9);
    check("bp sum", 32'(sum), 32'h46);
    held = sum;
    for (int i = 0; i < 5; i++) begin
      a = 8'hAA; b = 8'hAA; in_valid = (i % 2) == 0;
      tick();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp sum stable", 32'(sum), 32'(held));
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim release out_valid", 32'(out_valid), 32'd0);
    check("sim release in_ready", 32'(in_ready), 32'd1);
    check("sim release sum kept", 32'(sum), 32'(held));
    tick();
    in_valid = 1'b0;
    check("accept after release", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("post-bp latency", 32'(lat), 32'd9);
    check("post-bp sum", 32'(sum), 32'h03);
    release_result();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, lat);
    check("sub1 sum", 32'(sum), 32'hFE);
    check("sub1 cout", 32'(cout), 32'd0);
    check("sub1 ovf", 32'(ovf), 32'd0);
    release_result();
    run_op(8'h80, 8'h01, 1'b0, lat);
    check("sub2 sum", 32'(sum), 32'h7F);
    check("sub2 cout", 32'(cout), 32'd1);
    check("sub2 ovf", 32'(ovf), 32'd1);
    release_result();
    sub = 1'b0;
`endif

    // WIDTH=16 sweep against an a+b+cin model
    for (int k = 0; k < 4; k++) begin
      bpc = (k == 3) ? 16 : (1 << k);
      for (int n = 0; n < 40; n++) begin
        if (n == 0) begin
          ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1;
        end else if (n == 1) begin
          ra = 16'h7FFF; rb = 16'h0001; rc = 1'b0;
        end else begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        end
        full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        sw_a[k] = ra; sw_b[k] = rb; sw_cin[k] = rc; sw_iv[k] = 1'b1;
        tick();
        sw_iv[k] = 1'b0;
        lat = 1;
        while (!sw_ov[k] && lat < 40) begin
          tick();
          lat++;
        end
        check("sweep latency", 32'(lat), 32'(16 / bpc + 1));
        check("sweep sum", 32'(sw_sum[k]), 32'(full[15:0]));
        check("sweep cout", 32'(sw_co[k]), 32'(full[16]));
        check("sweep ovf", 32'(sw_ovf[k]),
              32'((ra[15] == rb[15]) && (full[15] != ra[15])));
        sw_or[k] = 1'b1;
        tick();
        sw_or[k] = 1'b0;
        check("sweep in_ready", 32'(sw_ir[k]), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
